// File: rtl/eth_rx_frame_checker_if.sv
// Byte-stream bundle for the RX frame checker: frame bytes in, payload bytes out.
// The checker takes the slave side; the byte source and payload sink take master.
interface eth_rx_frame_checker_if;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_last;
  logic       pl_valid;
  logic [7:0] pl_data;

  modport slave (
    input  rx_valid,
    input  rx_data,
    input  rx_last,
    output pl_valid,
    output pl_data
  );

  modport master (
    output rx_valid,
    output rx_data,
    output rx_last,
    input  pl_valid,
    input  pl_data
  );
endinterface

// File: rtl/eth_rx_frame_checker.sv
// Ethernet RX frame checker: destination filter, length and CRC32 checks,
// payload extraction through a 4-byte delay line, per-frame status and counters.
module eth_rx_frame_checker #(
  parameter int MIN_FRAME_BYTES = 18,
  parameter int MAX_FRAME_BYTES = 1518,
  parameter int BYTE_CNT_W      = 11
) (
  input  logic                    i_main_clk,
  input  logic                    i_rst,
  eth_rx_frame_checker_if.slave   rx_if,
  input  logic [47:0]             i_mac_addr,
  input  logic                    i_promiscuous,
  output logic                    o_frame_done,
  output logic                    o_frame_good,
  output logic                    o_frame_dropped,
  output logic [3:0]              o_frame_err,
  output logic [15:0]             o_good_count,
  output logic [15:0]             o_bad_count,
  output logic [15:0]             o_drop_count
);

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    BODY
  } state_e;

  localparam logic [31:0] CRC_RESIDUE = 32'hDEBB20E3;
  localparam logic [16:0] MIN_B = 17'(MIN_FRAME_BYTES);
  localparam logic [16:0] MAX_B = 17'(MAX_FRAME_BYTES);

  state_e                  state_q;
  logic [BYTE_CNT_W-1:0]   cnt_q;
  logic [31:0]             crc_q;
  logic                    ueq_q;
  logic                    bc_q;
  logic [15:0]             len_q;
  logic [3:0][7:0]         dly_q;
  logic                    pl_valid_q;
  logic [7:0]              pl_data_q;
  logic                    done_q;
  logic                    good_q;
  logic                    drop_q;
  logic [3:0]              err_q;
  logic [15:0]             good_cnt_q;
  logic [15:0]             bad_cnt_q;
  logic [15:0]             drop_cnt_q;

  logic                    first;
  logic [BYTE_CNT_W-1:0]   idx;
  logic [BYTE_CNT_W-1:0]   tot_d;
  logic [31:0]             crc_d;
  logic                    ueq_d;
  logic                    bc_d;
  logic [15:0]             len_d;
  logic [47:0]             mac_sh;
  logic                    match;
  logic                    len_mode;
  logic [16:0]             idx17;
  logic [16:0]             tot17;
  logic [16:0]             lim17;
  logic                    emit;
  logic [3:0]              err_d;

  function automatic logic [31:0] crc_byte(
    input logic [31:0] c,
    input logic [7:0]  d
  );
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      r = (r >> 1) ^ ((r[0] ^ d[i]) ? 32'hEDB88320 : 32'h0);
    end
    return r;
  endfunction

  // An IDLE state means the incoming byte is byte 0: per-frame state restarts.
  always_comb begin
    first  = (state_q == IDLE);
    idx    = first ? '0 : cnt_q;
    tot_d  = (&idx) ? idx : idx + 1'b1;
    crc_d  = crc_byte(first ? 32'hFFFFFFFF : crc_q, rx_if.rx_data);
    mac_sh = i_mac_addr << {idx[2:0], 3'b000};
    ueq_d  = first ? 1'b1 : ueq_q;
    bc_d   = first ? 1'b1 : bc_q;
    len_d  = first ? 16'h0 : len_q;
    if (idx < BYTE_CNT_W'(6)) begin
      ueq_d = ueq_d & (rx_if.rx_data == mac_sh[47:40]);
      bc_d  = bc_d & (rx_if.rx_data == 8'hFF);
    end
    if (idx == BYTE_CNT_W'(12)) len_d[15:8] = rx_if.rx_data;
    if (idx == BYTE_CNT_W'(13)) len_d[7:0]  = rx_if.rx_data;
    match    = ueq_d | bc_d | i_promiscuous;
    len_mode = (len_d <= 16'd1500);
    idx17    = 17'(idx);
    tot17    = 17'(tot_d);
    lim17    = 17'(len_d) + 17'd18;
    // Byte n-4 is payload when 14 <= n-4 < 14+L, i.e. 18 <= n < 18+L.
    emit     = match && (idx17 >= 17'd18) &&
               (!len_mode || (idx17 < lim17));
    err_d[0] = (crc_d != CRC_RESIDUE);
    err_d[1] = (tot17 < MIN_B);
    err_d[2] = (tot17 > MAX_B) || (&tot_d);
    err_d[3] = len_mode && (lim17 > tot17);
  end

  always_ff @(posedge i_main_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      crc_q      <= 32'hFFFFFFFF;
      ueq_q      <= 1'b0;
      bc_q       <= 1'b0;
      len_q      <= '0;
      dly_q      <= '0;
      pl_valid_q <= 1'b0;
      pl_data_q  <= '0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= '0;
      good_cnt_q <= '0;
      bad_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      pl_valid_q <= 1'b0;
      done_q     <= 1'b0;
      good_q     <= 1'b0;
      drop_q     <= 1'b0;
      err_q      <= '0;
      if (rx_if.rx_valid) begin
        cnt_q      <= tot_d;
        ueq_q      <= ueq_d;
        bc_q       <= bc_d;
        len_q      <= len_d;
        dly_q      <= {dly_q[2:0], rx_if.rx_data};
        pl_valid_q <= emit;
        if (emit) pl_data_q <= dly_q[3];
        crc_q <= rx_if.rx_last ? 32'hFFFFFFFF : crc_d;
        if (rx_if.rx_last) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
          if (!match) begin
            drop_q <= 1'b1;
            if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
          end else begin
            err_q  <= err_d;
            good_q <= (err_d == 4'h0);
            if (err_d == 4'h0) begin
              if (good_cnt_q != 16'hFFFF) good_cnt_q <= good_cnt_q + 1'b1;
            end else begin
              if (bad_cnt_q != 16'hFFFF) bad_cnt_q <= bad_cnt_q + 1'b1;
            end
          end
        end else begin
          case (state_q)
            IDLE:    state_q <= HEADER;
            HEADER:  if (idx == BYTE_CNT_W'(13)) state_q <= BODY;
            BODY:    state_q <= BODY;
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign rx_if.pl_valid  = pl_valid_q;
  assign rx_if.pl_data   = pl_data_q;
  assign o_frame_done    = done_q;
  assign o_frame_good    = good_q;
  assign o_frame_dropped = drop_q;
  assign o_frame_err     = err_q;
  assign o_good_count    = good_cnt_q;
  assign o_bad_count     = bad_cnt_q;
  assign o_drop_count    = drop_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// Directed bench for eth_rx_frame_checker; FCS bytes are generated by a
// bench-side CRC32 so every frame's expected status is known by construction.
module tb_eth_rx_frame_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [47:0] mac;
  logic        promisc;
  logic        done;
  logic        good;
  logic        dropped;
  logic [3:0]  err;
  logic [15:0] gc;
  logic [15:0] bc;
  logic [15:0] dc;

  always #5 clk = ~clk;

  eth_rx_frame_checker_if bus ();

  eth_rx_frame_checker dut (
    .i_main_clk      (clk),
    .i_rst           (rst),
    .rx_if           (bus),
    .i_mac_addr      (mac),
    .i_promiscuous   (promisc),
    .o_frame_done    (done),
    .o_frame_good    (good),
    .o_frame_dropped (dropped),
    .o_frame_err     (err),
    .o_good_count    (gc),
    .o_bad_count     (bc),
    .o_drop_count    (dc)
  );

  int          n_vec  = 0;
  int          n_miss = 0;
  int          eg     = 0;
  int          eb     = 0;
  int          ed     = 0;
  logic [7:0]  fb [0:2047];
  int          flen;
  logic [7:0]  pq [$];
  int          ndone;
  logic        s_good;
  logic        s_drop;
  logic [3:0]  s_err;

  always @(negedge clk) begin
    if (bus.pl_valid) pq.push_back(bus.pl_data);
    if (done) begin
      ndone++;
      s_good = good;
      s_drop = dropped;
      s_err  = err;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] crc_model(input logic [31:0] c,
                                            input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    repeat (8) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

  task automatic hdr(input logic [47:0] dst, input logic [15:0] tl);
    for (int i = 0; i < 6; i++) fb[i] = dst[8*(5-i) +: 8];
    for (int i = 6; i < 12; i++) fb[i] = 8'hFF;
    fb[12] = tl[15:8];
    fb[13] = tl[7:0];
  endtask

  task automatic fcs(input int n);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < n; i++) c = crc_model(c, fb[i]);
    c = ~c;
    fb[n]   = c[7:0];
    fb[n+1] = c[15:8];
    fb[n+2] = c[23:16];
    fb[n+3] = c[31:24];
    flen = n + 4;
  endtask

  task automatic build_t1(input logic [47:0] dst);
    hdr(dst, 16'h000C);
    for (int i = 0; i < 12; i++) fb[14+i] = 8'(i);
    fcs(26);
  endtask

  task automatic send(input int reps, input bit gaps);
    pq.delete();
    ndone = 0;
    for (int r = 0; r < reps; r++) begin
      for (int i = 0; i < flen; i++) begin
        bus.rx_valid = 1'b1;
        bus.rx_data  = fb[i];
        bus.rx_last  = (i == flen - 1);
        @(posedge clk); #1;
        if (gaps) begin
          bus.rx_valid = 1'b0;
          bus.rx_last  = 1'b0;
          @(posedge clk); #1;
        end
      end
    end
    bus.rx_valid = 1'b0;
    bus.rx_last  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string tag, input int exp_n,
                             input bit exp_good, input bit exp_drop,
                             input logic [3:0] exp_err,
                             input logic [3:0] mask);
    chk({tag, ".done"}, ndone, 1);
    chk({tag, ".good"}, s_good, exp_good);
    chk({tag, ".drop"}, s_drop, exp_drop);
    chk({tag, ".err"}, s_err & mask, exp_err);
    chk({tag, ".npay"}, pq.size(), exp_n);
    for (int i = 0; i < pq.size() && i < exp_n; i++)
      chk({tag, ".pay"}, pq[i], fb[14+i]);
    chk({tag, ".gcnt"}, gc, eg);
    chk({tag, ".bcnt"}, bc, eb);
    chk({tag, ".dcnt"}, dc, ed);
  endtask

  initial begin
    rst          = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    bus.rx_last  = 1'b0;
    mac          = 48'h1A2B3C4D5E6F;
    promisc      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.done", done, 0);
    chk("rst.pv", bus.pl_valid, 0);
    chk("rst.gcnt", gc, 0);
    chk("rst.bcnt", bc, 0);
    chk("rst.dcnt", dc, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    build_t1(mac);
    send(1, 0);
    eg = 1;
    check_frame("t1", 12, 1, 0, 4'h0, 4'hF);

    build_t1(mac);
    fb[20] = 8'hFF;
    send(1, 0);
    eb = 1;
    check_frame("crcbad", 12, 0, 0, 4'h1, 4'hF);

    build_t1(mac);
    mac = 48'h1A2B3C4D5E70;
    send(1, 0);
    ed = 1;
    check_frame("nomatch", 0, 0, 1, 4'h0, 4'hF);
    promisc = 1'b1;
    send(1, 0);
    eg = 2;
    check_frame("promisc", 12, 1, 0, 4'h0, 4'hF);
    promisc = 1'b0;
    mac = 48'h1A2B3C4D5E6F;

    hdr(mac, 16'h0000);
    flen = 10;
    send(1, 0);
    eb = 2;
    check_frame("runt", 0, 0, 0, 4'b0010, 4'b0010);

    hdr(mac, 16'h000C);
    for (int i = 0; i < 12; i++) fb[14+i] = 8'(8'h40 + i);
    for (int i = 26; i < 60; i++) fb[i] = 8'h00;
    fcs(60);
    send(1, 0);
    eg = 3;
    check_frame("padded", 12, 1, 0, 4'h0, 4'hF);

    hdr(mac, 16'h0800);
    for (int i = 0; i < 46; i++) fb[14+i] = 8'(i * 7);
    fcs(60);
    send(1, 0);
    eg = 4;
    check_frame("etype", 46, 1, 0, 4'h0, 4'hF);

    build_t1(mac);
    send(1, 1);
    eg = 5;
    check_frame("gaps", 12, 1, 0, 4'h0, 4'hF);

    build_t1(48'hFFFFFFFFFFFF);
    send(1, 0);
    eg = 6;
    check_frame("bcast", 12, 1, 0, 4'h0, 4'hF);

    build_t1(mac);
    send(2, 0);
    eg = 8;
    chk("b2b.done", ndone, 2);
    chk("b2b.npay", pq.size(), 24);
    for (int i = 0; i < pq.size() && i < 24; i++)
      chk("b2b.pay", pq[i], fb[14 + (i % 12)]);
    chk("b2b.gcnt", gc, eg);

    build_t1(mac);
    for (int i = 0; i < 15; i++) begin
      bus.rx_valid = 1'b1;
      bus.rx_data  = fb[i];
      bus.rx_last  = 1'b0;
      @(posedge clk); #1;
    end
    bus.rx_data = fb[15];
    #1 rst = 1'b1;
    #1;
    chk("mrst.done", done, 0);
    chk("mrst.good", good, 0);
    chk("mrst.pv", bus.pl_valid, 0);
    chk("mrst.gcnt", gc, 0);
    chk("mrst.bcnt", bc, 0);
    chk("mrst.dcnt", dc, 0);
    bus.rx_valid = 1'b0;
    #1 rst = 1'b0;
    @(posedge clk); #1;
    send(1, 0);
    eg = 1;
    eb = 0;
    ed = 0;
    check_frame("postrst", 12, 1, 0, 4'h0, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
